// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Optional even parity is selected with the macro UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk, input int baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART serializer.
// Pushes into a full FIFO are dropped; pops from an empty FIFO are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [UART_DATA_BITS-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage contents.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter: valid/ready byte input, 8N1 serial output.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock_50MHz,
    input  logic                        reset_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        UART_Tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic push_acc;
    logic bit_end;

    assign tx_ready = !fifo_full;
    assign push_acc = tx_valid && !fifo_full;
    assign bit_end  = (cnt_q == CNT_LAST);
    assign UART_Tx  = tx_q;
    assign tx_busy  = busy_q;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clock_50MHz),
        .rst_n(reset_n),
        .push (tx_valid),
        .wdata(tx_data),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // Frame sequencing: baud counter, shift register and state transitions.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;
        cnt_d     = bit_end ? '0 : cnt_q + CNT_ONE;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^fifo_rdata;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        parity_d  = ^fifo_rdata;
`endif
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line level and busy flag for the state being entered.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START: tx_d = 1'b0;
            DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || !fifo_empty || push_acc;
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clock_50MHz) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (DIV=4 instance plus a default-rate instance).
// Frame length and parity checks follow UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

    localparam int DIV  = 4;
    localparam int DIVD = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    logic [7:0] d_data;
    logic       d_valid;
    logic       d_ready;
    logic       d_line;
    logic       d_busy;
    logic [2:0] d_count;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (12_500_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clock_50MHz(clk),
        .reset_n    (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_Tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_serializer dut_d (
        .clock_50MHz(clk),
        .reset_n    (rst_n),
        .tx_data    (d_data),
        .tx_valid   (d_valid),
        .tx_ready   (d_ready),
        .UART_Tx    (d_line),
        .tx_busy    (d_busy),
        .fifo_count (d_count)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_line(input logic [7:0] b, input logic par,
                                      input int idx);
        int k;
        k = idx / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NBITS - 1) return 1'b1;
        return par;
    endfunction

    task automatic check_frame(input logic [7:0] b, input logic par,
                               input int skip);
        for (int i = skip; i < FLEN; i++) begin
            check($sformatf("line byte %02h idx %0d", b, i),
                  {31'd0, uart_tx}, {31'd0, exp_line(b, par, i)});
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        d_valid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic       bad;
        logic [7:0] rx;
        logic       stop_bit;
        int         n;
        logic [7:0] seq2 [5];
        logic       par2 [5];
        logic [7:0] seq3 [5];
        logic       par3 [5];

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h00, 1'b0};
        seq2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        par2 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        seq3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'hAA};
        par3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        tx_data = 8'h00;
        d_data  = 8'h00;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        d_valid  = 1'b0;
        tick();
        check("reset line", {31'd0, uart_tx}, 32'd1);
        check("reset busy", {31'd0, tx_busy}, 32'd0);
        check("reset ready", {31'd0, tx_ready}, 32'd1);
        check("reset count", {29'd0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single frames from idle
        for (int v = 0; v < 6; v++) begin
            tx_data  = vecs[v].data;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            check("push count", {29'd0, fifo_count}, 32'd1);
            check("push line idle", {31'd0, uart_tx}, 32'd1);
            check("push busy", {31'd0, tx_busy}, 32'd1);
            tick();
            check_frame(vecs[v].data, vecs[v].par, 0);
            check("end busy", {31'd0, tx_busy}, 32'd0);
            check("end line", {31'd0, uart_tx}, 32'd1);
            tick();
            tick();
        end

        // five back-to-back bytes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_data  = seq2[i];
            tx_valid = 1'b1;
            check("burst ready", {31'd0, tx_ready}, 32'd1);
            tick();
        end
        tx_valid = 1'b0;
        check("burst peak count", {29'd0, fifo_count}, 32'd4);
        check("burst full ready", {31'd0, tx_ready}, 32'd0);
        check_frame(seq2[0], par2[0], 3);
        for (int i = 1; i < 5; i++) begin
            check("burst count", {29'd0, fifo_count}, 32'(4 - i));
            check_frame(seq2[i], par2[i], 0);
        end
        check("burst done busy", {31'd0, tx_busy}, 32'd0);

        // byte held while full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_data  = seq3[i];
            tx_valid = 1'b1;
            tick();
        end
        tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_data  = seq3[i];
            tx_valid = 1'b1;
            tick();
        end
        tx_data = 8'h15;
        tick();
        tx_valid = 1'b0;
        check_frame(seq3[0], par3[0], 3);
        do_reset();
        tx_data  = 8'h10;
        tx_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tx_data = seq3[i];
            tick();
        end
        tx_data = 8'hAA;
        bad = 1'b0;
        repeat (FLEN - 4) begin
            tick();
            if (tx_ready !== 1'b0) bad = 1'b1;
        end
        check("hold ready low", {31'd0, bad}, 32'd0);
        tick();
        check("hold ready back", {31'd0, tx_ready}, 32'd1);
        check("hold count 3", {29'd0, fifo_count}, 32'd3);
        tick();
        tx_valid = 1'b0;
        check("hold accepted", {29'd0, fifo_count}, 32'd4);
        check_frame(seq3[0], par3[0], 1);
        for (int i = 1; i < 5; i++) begin
            check_frame(seq3[i], par3[i], 0);
        end
        check("hold done busy", {31'd0, tx_busy}, 32'd0);

        // reset mid-frame
        do_reset();
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h11;
        tick();
        tx_data = 8'h22;
        tick();
        tx_valid = 1'b0;
        check("mid count", {29'd0, fifo_count}, 32'd2);
        repeat (16) tick();
        check("mid bit3", {31'd0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid rst line", {31'd0, uart_tx}, 32'd1);
        check("mid rst count", {29'd0, fifo_count}, 32'd0);
        check("mid rst busy", {31'd0, tx_busy}, 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (3 * FLEN) begin
            tick();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("mid quiet", {31'd0, bad}, 32'd0);

        // default rate into an RX model
        d_data  = 8'h41;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        n = 0;
        while (d_line === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("rx start seen", {31'd0, d_line}, 32'd0);
        repeat (DIVD / 2) tick();
        check("rx start mid", {31'd0, d_line}, 32'd0);
        rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            repeat (DIVD) tick();
            rx[i] = d_line;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIVD) tick();
        check("rx parity", {31'd0, d_line}, 32'd0);
`endif
        repeat (DIVD) tick();
        stop_bit = d_line;
        check("rx byte", {24'd0, rx}, 32'h41);
        check("rx stop", {31'd0, stop_bit}, 32'd1);
        repeat (DIVD) tick();
        check("rx busy end", {31'd0, d_busy}, 32'd0);
        check("rx count end", {29'd0, d_count}, 32'd0);
        check("rx ready end", {31'd0, d_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
